apb_master_n: RTL and testbench



---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_addr_decoder.sv | 31 +++
 rtl/apb_master_n.sv | 194 +++++++++++++++++++
 tb/tb_apb_master_n.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and parameter defaults for the multi-slave APB master.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DERR   = 2'd3
  } apb_state_e;

  localparam int          DEF_NUM_SLV   = 11;
  localparam int          DEF_DATA_W    = 32;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
  localparam int          DEF_SLV_SHIFT = 12;
  localparam int          DEF_TIMEOUT   = 16;
  localparam int          CNT_W         = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a byte address onto one of NUM_SLV equally sized peripheral regions.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLV   = DEF_NUM_SLV,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          SLV_SHIFT = DEF_SLV_SHIFT,
  parameter int          IDX_W     = idx_width(NUM_SLV)
) (
  input  logic [31:0]        addr,
  output logic               hit,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_SLV-1:0] sel
);

  logic [32:0] off;
  logic [31:0] slot;

  // The 33-bit subtract exposes "below base" as a borrow; comparing the
  // region number avoids overflowing the window end near the top of memory.
  always_comb begin
    off  = {1'b0, addr} - {1'b0, BASE_ADDR};
    slot = off[31:0] >> SLV_SHIFT;
    hit  = !off[32] && (slot < 32'(NUM_SLV));
    idx  = slot[IDX_W-1:0];
    for (int i = 0; i < NUM_SLV; i++) begin
      sel[i] = hit && (slot == 32'(i));
    end
  end

endmodule

// File: rtl/apb_master_n.sv
// APB master bridging a simple request strobe to NUM_SLV address-decoded
// peripherals, with ACCESS-phase timeout and decode-error completion.
module apb_master_n
  import apb_pkg::*;
#(
  parameter int          NUM_SLV   = DEF_NUM_SLV,
  parameter int          DATA_W    = DEF_DATA_W,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          SLV_SHIFT = DEF_SLV_SHIFT,
  parameter int          TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  output logic [31:0]               PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  input  logic                      transfer,
  input  logic                      write,
  input  logic [31:0]               addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       strb,
  output logic                      busy,
  output logic                      ready,
  output logic [DATA_W-1:0]         rdata,
  output logic                      error,
  output apb_state_e                dbg_state
);

  localparam int IDX_W  = idx_width(NUM_SLV);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e          state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic                write_q, write_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic [NUM_SLV-1:0]  dec_sel;
  logic [DATA_W-1:0]   slv_rdata [NUM_SLV];
  logic                timed_out;

  apb_addr_decoder #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR),
    .SLV_SHIFT (SLV_SHIFT),
    .IDX_W     (IDX_W)
  ) u_dec (
    .addr (addr),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .sel  (dec_sel)
  );

  always_comb begin
    for (int i = 0; i < NUM_SLV; i++) begin
      slv_rdata[i] = PRDATA[i*DATA_W +: DATA_W];
    end
  end

  assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    write_d   = write_q;
    idx_d     = idx_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pstrb_d   = pstrb_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    error_d   = error_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          addr_d  = addr;
          wdata_d = wdata;
          strb_d  = strb;
          write_d = write;
          idx_d   = dec_idx;
          if (dec_hit) begin
            state_d  = ST_SETUP;
            psel_d   = dec_sel;
            pwrite_d = write;
            pstrb_d  = write ? strb : '0;
            cnt_d    = '0;
          end else begin
            state_d = ST_DERR;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // A slave answering on the last allowed cycle still completes normally.
        if (PREADY[idx_q] || timed_out) begin
          state_d   = ST_IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          pstrb_d   = '0;
          ready_d   = 1'b1;
          if (PREADY[idx_q]) begin
            error_d = PSLVERR[idx_q];
            rdata_d = write_q ? '0 : slv_rdata[idx_q];
          end else begin
            error_d = 1'b1;
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DERR: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        error_d = 1'b1;
        rdata_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pstrb_q   <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pstrb_q   <= pstrb_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      rdata_q   <= rdata_d;
    end
  end

  assign PADDR     = addr_q;
  assign PWDATA    = wdata_q;
  assign PSTRB     = pstrb_q;
  assign PWRITE    = pwrite_q;
  assign PENABLE   = penable_q;
  assign PSEL      = psel_q;
  assign busy      = (state_q != ST_IDLE);
  assign ready     = ready_q;
  assign error     = error_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master_n.sv
// Directed bench for apb_master_n: driver tasks push expected completions,
// a negedge monitor pops and compares each ready pulse.
module tb_apb_master_n;
  import apb_pkg::*;

  localparam int NUM_SLV = 11;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;
  localparam int TIMEOUT = 4;

  // clock / reset
  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  logic [31:0]               PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic [STRB_W-1:0]         PSTRB;
  logic                      PWRITE;
  logic                      PENABLE;
  logic [NUM_SLV-1:0]        PSEL;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;
  logic                      transfer = 1'b0;
  logic                      write    = 1'b0;
  logic [31:0]               addr     = '0;
  logic [DATA_W-1:0]         wdata    = '0;
  logic [STRB_W-1:0]         strb     = '0;
  logic                      busy;
  logic                      ready;
  logic [DATA_W-1:0]         rdata;
  logic                      error;
  apb_state_e                dbg_state;

  apb_master_n #(
    .NUM_SLV   (NUM_SLV),
    .DATA_W    (DATA_W),
    .BASE_ADDR (32'h1000_0000),
    .SLV_SHIFT (12),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PWRITE    (PWRITE),
    .PENABLE   (PENABLE),
    .PSEL      (PSEL),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .transfer  (transfer),
    .write     (write),
    .addr      (addr),
    .wdata     (wdata),
    .strb      (strb),
    .busy      (busy),
    .ready     (ready),
    .rdata     (rdata),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] mon_exp;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // slave model: only the targeted slave answers; others present noise data
  int              slv_t   = 0;
  int              waits_t = 0;
  logic            never_t = 1'b0;
  logic            err_t   = 1'b0;
  logic [31:0]     rd_t    = '0;
  int              acc     = 0;

  always @(negedge PCLK) begin
    PREADY  = '0;
    PSLVERR = '0;
    for (int i = 0; i < NUM_SLV; i++) PRDATA[i*DATA_W +: DATA_W] = {16'h0BAD, 16'(i)};
    PRDATA[slv_t*DATA_W +: DATA_W] = rd_t;
    if (PENABLE && PSEL[slv_t]) begin
      if (!never_t && acc == waits_t) begin
        PREADY[slv_t]  = 1'b1;
        PSLVERR[slv_t] = err_t;
      end
      acc++;
    end else begin
      acc = 0;
    end
  end

  // monitor
  always @(negedge PCLK) begin
    if (ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready: got ready=1 rdata=%0h error=%0b, expected no completion", rdata, error);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("response", {error, rdata}, mon_exp);
      end
    end
  end

  // driver: issue one request at the current negedge, follow it to completion
  task automatic run_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input int slv, input int waits,
                          input logic never, input logic serr, input logic [31:0] rdv,
                          input logic [NUM_SLV-1:0] exp_sel, input int exp_lat,
                          input int exp_psel, input int exp_pen, input logic exp_err,
                          input logic [31:0] exp_rd, input logic pulse_busy);
    int   n0;
    int   psel_c;
    int   pen_c;
    logic seen;
    slv_t = slv; waits_t = waits; never_t = never; err_t = serr; rd_t = rdv;
    transfer = 1'b1; write = wr; addr = a; wdata = wd; strb = st;
    n0 = cyc;
    exp_q.push_back({exp_err, exp_rd});
    psel_c = 0; pen_c = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge PCLK);
      transfer = pulse_busy && (i == 1);
      if (pulse_busy && i == 1) begin
        write = 1'b1;
        addr  = 32'h1000_0000;
      end
      if (PSEL != '0) begin
        if (psel_c == 0) begin
          chk("psel", PSEL, exp_sel);
          chk("setup_ctrl", {PENABLE, PWRITE, PADDR}, {1'b0, wr, a});
          chk("pstrb", PSTRB, wr ? st : 4'h0);
          if (wr) chk("pwdata", PWDATA, wd);
        end
        psel_c++;
      end
      if (PENABLE) pen_c++;
      if (ready) seen = 1'b1;
    end
    transfer = 1'b0;
    chk("completed", seen, 1);
    chk("latency", cyc - n0, exp_lat);
    chk("psel_cycles", psel_c, exp_psel);
    chk("penable_cycles", pen_c, exp_pen);
    chk("idle_outputs", {PSEL, PENABLE, PWRITE, PSTRB, busy}, '0);
  endtask

  initial begin
    repeat (3) @(negedge PCLK);
    chk("rst_bus", {PSEL, PENABLE, PWRITE, PSTRB, PADDR}, '0);
    chk("rst_resp", {ready, error, rdata}, '0);
    chk("rst_state", {busy, dbg_state}, {1'b0, ST_IDLE});
    PRESET = 1'b0;

    // zero-wait write to slave 3; read data must be forced to zero
    run_xfer(1'b1, 32'h1000_3004, 32'hA5A5_0001, 4'hF, 3, 0, 1'b0, 1'b0, 32'hFFFF_FFFF,
             11'b000_0000_1000, 3, 2, 1, 1'b0, 32'h0, 1'b0);
    // back-to-back read, slave 10 after three wait states
    run_xfer(1'b0, 32'h1000_A000, 32'h0, 4'hF, 10, 3, 1'b0, 1'b0, 32'hDEAD_BEEF,
             11'b100_0000_0000, 6, 5, 4, 1'b0, 32'hDEAD_BEEF, 1'b0);
    // unmapped address
    run_xfer(1'b0, 32'h2000_0000, 32'h0, 4'h0, 0, 0, 1'b0, 1'b0, 32'h0,
             11'b0, 2, 0, 0, 1'b1, 32'h0, 1'b0);
    // slave 2 never ready: timeout after four ACCESS cycles
    run_xfer(1'b0, 32'h1000_2000, 32'h0, 4'h0, 2, 0, 1'b1, 1'b0, 32'h1234_5678,
             11'b000_0000_0100, 6, 5, 4, 1'b1, 32'h0, 1'b0);
    // slave 2 ready on the last allowed cycle: normal completion
    run_xfer(1'b0, 32'h1000_2008, 32'h0, 4'h0, 2, 3, 1'b0, 1'b0, 32'h0BEE_F002,
             11'b000_0000_0100, 6, 5, 4, 1'b0, 32'h0BEE_F002, 1'b0);
    // slave error on slave 5 with a request pulsed while busy
    run_xfer(1'b0, 32'h1000_5010, 32'h0, 4'h0, 5, 0, 1'b0, 1'b1, 32'hCAFE_0005,
             11'b000_0010_0000, 3, 2, 1, 1'b1, 32'hCAFE_0005, 1'b1);
    repeat (2) @(negedge PCLK);
    chk("resp_hold", {error, rdata}, {1'b1, 32'hCAFE_0005});
    // last word of the window, partial strobes, one wait state
    run_xfer(1'b1, 32'h1000_AFFC, 32'h0000_BEEF, 4'h3, 10, 1, 1'b0, 1'b0, 32'hFFFF_FFFF,
             11'b100_0000_0000, 4, 3, 2, 1'b0, 32'h0, 1'b0);
    // just below base and just past the window end
    run_xfer(1'b0, 32'h0FFF_FFFC, 32'h0, 4'h0, 0, 0, 1'b0, 1'b0, 32'h0,
             11'b0, 2, 0, 0, 1'b1, 32'h0, 1'b0);
    run_xfer(1'b0, 32'h1000_B000, 32'h0, 4'h0, 0, 0, 1'b0, 1'b0, 32'h0,
             11'b0, 2, 0, 0, 1'b1, 32'h0, 1'b0);

    // reset while in ACCESS: bus drops, no completion
    slv_t = 1; never_t = 1'b1; rd_t = 32'h0;
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000;
    @(negedge PCLK);
    transfer = 1'b0;
    for (int i = 0; i < 10 && !PENABLE; i++) @(negedge PCLK);
    chk("reach_access", PENABLE, 1);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("rst_mid_bus", {PSEL, PENABLE, ready, busy}, '0);
    chk("rst_mid_resp", {error, rdata}, '0);
    PRESET = 1'b0;
    never_t = 1'b0;
    @(negedge PCLK);
    run_xfer(1'b0, 32'h1000_1000, 32'h0, 4'h0, 1, 0, 1'b0, 1'b0, 32'h1111_2222,
             11'b000_0000_0010, 3, 2, 1, 1'b0, 32'h1111_2222, 1'b0);

    repeat (4) @(negedge PCLK);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
